// File: rtl/gpr_file_sb.sv
// gpr_file_sb: general-purpose register file with a per-register busy scoreboard.
//
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   wen0/waddr0/wdata0 - write port 0 (EXU results)
//   wen1/waddr1/wdata1 - write port 1 (LSU / long-latency results, also clears busy)
//   sb_set/sb_addr     - mark a register busy at issue
//   raddr/rdata/rbusy  - NRD combinational read ports with busy flags (packed per port)
//   wr_conflict        - registered: both write ports hit the same live address last cycle
//   dbg_addr/dbg_data  - debug read of the stored value, never bypassed
module gpr_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic                wr_conflict,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_conflict_q;
  logic             wr_conflict_d;

  // Per-register next state. Register 0 is a constant when hardwired to zero,
  // so it can never be written or become busy.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign regs_d[gi] = '0;
        assign busy_d[gi] = 1'b0;
      end else begin : g_live
        logic hit0;
        logic hit1;
        logic sb_hit;
        assign hit0   = wen0 && (waddr0 == AW'(gi));
        assign hit1   = wen1 && (waddr1 == AW'(gi));
        assign sb_hit = sb_set && (sb_addr == AW'(gi));
        // Port 1 is younger in writeback order, so it wins a collision.
        assign regs_d[gi] = hit1 ? wdata1 : (hit0 ? wdata0 : regs_q[gi]);
        // A same-cycle set means a new producer was issued: set beats clear.
        assign busy_d[gi] = sb_hit | (busy_q[gi] & ~hit1);
      end
    end
  endgenerate

  assign wr_conflict_d = wen0 && wen1 && (waddr0 == waddr1) &&
                         !((ZERO_REG != 0) && (waddr0 == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Read ports. Forwarding is suppressed while rst is high because the
  // in-flight write is discarded, so reads must show the cleared state.
  generate
    for (genvar gk = 0; gk < NRD; gk++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            byp0;
      logic            byp1;
      logic [XLEN-1:0] rd;
      assign ra   = raddr[gk*AW +: AW];
      assign byp0 = (BYPASS != 0) && !rst && wen0 && (waddr0 == ra);
      assign byp1 = (BYPASS != 0) && !rst && wen1 && (waddr1 == ra);
      always_comb begin
        rd = regs_q[ra];
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd = '0;
        end else if (byp1) begin
          rd = wdata1;
        end else if (byp0) begin
          rd = wdata0;
        end
      end
      assign rdata[gk*XLEN +: XLEN] = rd;
      // Data forwarded from port 1 resolves the hazard this very cycle.
      assign rbusy[gk] = busy_q[ra] & ~byp1;
    end
  endgenerate

  assign wr_conflict = wr_conflict_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wen0, wen1, sb_set;
  logic [AW-1:0]       waddr0, waddr1, sb_addr, dbg_addr;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wr_conflict;
  logic [XLEN-1:0]     dbg_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  gpr_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wr_conflict(wr_conflict),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural register values, busy set, conflict flag.
  bit [XLEN-1:0] m_regs [NREGS];
  bit            m_busy [NREGS];
  bit            m_conf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = wen0 && wen1 && (waddr0 == waddr1) && (waddr0 != 0);
      if (wen0 && waddr0 != 0) m_regs[waddr0] = wdata0;
      if (wen1 && waddr1 != 0) m_regs[waddr1] = wdata1;   // younger result lands last
      if (wen1) m_busy[waddr1] = 1'b0;
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1; // new producer overrides clear
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!rst && wen1 && waddr1 == a) return wdata1;
    if (!rst && wen0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!rst && wen1 && waddr1 == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: every negedge the outputs are checked against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("model_rdata%0d", k), 64'(rdata[k*XLEN +: XLEN]),
            64'(exp_rd(raddr[k*AW +: AW])));
        chk($sformatf("model_rbusy%0d", k), 64'(rbusy[k]), 64'(exp_busy(raddr[k*AW +: AW])));
      end
      chk("model_wr_conflict", 64'(wr_conflict), 64'(m_conf));
      chk("model_dbg_data", 64'(dbg_data), 64'(m_regs[dbg_addr]));
    end
  end

  task automatic idle();
    wen0 = 0; wen1 = 0; sb_set = 0;
    waddr0 = 0; waddr1 = 0; sb_addr = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    chk({tag, "_rbusy"}, 64'(rbusy), 64'(0));
    chk({tag, "_dbg"}, 64'(dbg_data), 64'(0));
    chk({tag, "_wrc"}, 64'(wr_conflict), 64'(0));
  endtask

  initial begin
    idle();
    raddr = '0;
    dbg_addr = 0;
    rst = 1'b1;
    chk_en = 1'b1;
    next(); next();
    #1 chk_reset_outputs("reset_hold");
    rst = 1'b0;

    // Basic write / read
    wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    next(); idle(); set_ra(0, 5); dbg_addr = 5;
    #1 chk("basic_rd", 64'(rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("basic_dbg", 64'(dbg_data), 64'hDEAD_BEEF);
    wen0 = 1; waddr0 = 0; wdata0 = 32'hDEADBEEF;
    next(); idle(); set_ra(0, 0); dbg_addr = 0;
    #1 chk("zero_rd", 64'(rdata[31:0]), 64'(0));

    // Bypass on port 1 read port 1
    wen1 = 1; waddr1 = 7; wdata1 = 32'h12345678; set_ra(1, 7);
    #1 chk("bypass_rd", 64'(rdata[63:32]), 64'h1234_5678);
    next(); idle();

    // Collision on 9 then on 0
    wen0 = 1; waddr0 = 9; wdata0 = 32'h1; wen1 = 1; waddr1 = 9; wdata1 = 32'h2;
    next(); idle(); set_ra(0, 9);
    #1 chk("coll_val", 64'(rdata[31:0]), 64'h2);
    chk("coll_wrc1", 64'(wr_conflict), 64'(1));
    next();
    #1 chk("coll_wrc_once", 64'(wr_conflict), 64'(0));
    wen0 = 1; waddr0 = 0; wdata0 = 32'h1; wen1 = 1; waddr1 = 0; wdata1 = 32'h2;
    next(); idle();
    #1 chk("coll0_wrc", 64'(wr_conflict), 64'(0));

    // Scoreboard
    sb_set = 1; sb_addr = 3; set_ra(0, 3); set_ra(1, 3);
    #1 chk("sb_same_cycle", 64'(rbusy), 64'(0));
    next(); idle();
    #1 chk("sb_set", 64'(rbusy), 64'b11);
    wen1 = 1; waddr1 = 3; wdata1 = 32'h33;
    #1 chk("sb_clr_bypass", 64'(rbusy), 64'(0));
    next(); idle();
    #1 chk("sb_clr_after", 64'(rbusy), 64'(0));
    sb_set = 1; sb_addr = 3;
    next(); idle(); sb_set = 1; sb_addr = 3; wen1 = 1; waddr1 = 3; wdata1 = 32'h44;
    next(); idle();
    #1 chk("sb_set_wins", 64'(rbusy), 64'b11);
    wen0 = 1; waddr0 = 3; wdata0 = 32'h55;
    next(); idle();
    #1 chk("sb_port0_nochg", 64'(rbusy), 64'b11);

    // Reset mid-operation discards pending write and busy
    sb_set = 1; sb_addr = 4;
    next(); idle(); set_ra(0, 4); set_ra(1, 4); dbg_addr = 4;
    wen0 = 1; waddr0 = 4; wdata0 = 32'hAA;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset_async");
    next(); rst = 1'b0; idle();
    #1 chk("rst_mid_rd", 64'(rdata[31:0]), 64'(0));
    chk("rst_mid_busy", 64'(rbusy), 64'(0));

    // Randomized traffic checked by the compare process
    for (int n = 0; n < 600; n++) begin
      next();
      if (rst) rst = 1'b0;
      wen0    = $urandom_range(0, 1);
      wen1    = $urandom_range(0, 2) == 0;
      sb_set  = $urandom_range(0, 2) == 0;
      waddr0  = AW'($urandom_range(0, 7));
      waddr1  = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      sb_addr = AW'($urandom_range(0, 7));
      wdata0  = $urandom;
      wdata1  = $urandom;
      set_ra(0, AW'($urandom_range(0, 7)));
      set_ra(1, AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)));
      dbg_addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
      end
    end
    next();
    rst = 1'b0;
    idle();
    next();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
